// File: rtl/seg7_to_bcd_capture.sv
// seg7_to_bcd_capture
// Snoops a multiplexed, active-low 7-segment display bus and recovers the BCD
// value shown on each digit. Segment and anode lines are synchronised, then a
// pattern must stay constant for STABLE_CYCLES samples before it is captured
// into the digit selected by the anodes.
module seg7_to_bcd_capture #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  err,
    output logic                  frame_stb
);

    localparam int SW = DIGITS + 7;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // The sample seen on entry to TRACK and the capturing sample itself make up
    // two of the required identical samples, so the counter only needs to reach
    // STABLE_CYCLES-2 at the capture edge.
    localparam logic [CW-1:0] CAPTURE_AT = CW'(STABLE_CYCLES - 2);
    localparam logic [CW-1:0] CNT_MAX    = CW'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        HOLD
    } state_t;

    state_t state, state_next;

    logic [SW-1:0]     sync1, sync2, sample_prev;
    logic [DIGITS-1:0] sample_an;
    logic [6:0]        sample_seg;
    logic              changed;

    logic [DIGITS-1:0] an_onehot;
    logic              an_valid;
    logic [IW-1:0]     an_idx;
    logic [DIGITS-1:0] digit_sel;
    logic [DIGITS-1:0] mask_next;
    logic [DIGITS-1:0] frame_mask;

    logic [3:0]        nibble;
    logic              seg_bad;

    logic [CW-1:0]     cnt;
    logic              capture;
    logic              cnt_clr;

    // Map an active-low abcdefg pattern to BCD; blank is 4'hF, anything else 4'hE.
    function automatic logic [3:0] decode_seg(input logic [6:0] p);
        logic [3:0] d;
        case (p)
            7'b0000001: d = 4'h0;
            7'b1001111: d = 4'h1;
            7'b0010010: d = 4'h2;
            7'b0000110: d = 4'h3;
            7'b1001100: d = 4'h4;
            7'b0100100: d = 4'h5;
            7'b0100000: d = 4'h6;
            7'b0001101: d = 4'h7;
            7'b0000000: d = 4'h8;
            7'b0000100: d = 4'h9;
            7'b1111111: d = 4'hF;
            default:    d = 4'hE;
        endcase
        return d;
    endfunction

    // Two-flop synchroniser plus a copy of the previous sample for change detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1       <= '1;
            sync2       <= '1;
            sample_prev <= '1;
        end else begin
            sync1       <= {an, seg};
            sync2       <= sync1;
            sample_prev <= sync2;
        end
    end

    assign sample_an  = sync2[SW-1:7];
    assign sample_seg = sync2[6:0];
    assign changed    = (sync2 != sample_prev);
    assign nibble     = decode_seg(sample_seg);
    assign seg_bad    = (nibble == 4'hE);

    // Anode check: exactly one low select, and which digit it addresses.
    always_comb begin
        an_onehot = ~sample_an;
        an_valid  = (an_onehot != '0) && ((an_onehot & (an_onehot - 1'b1)) == '0);
        an_idx    = '0;
        digit_sel = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (an_onehot[i]) begin
                an_idx = IW'(i);
            end
        end
        for (int i = 0; i < DIGITS; i++) begin
            digit_sel[i] = an_valid && (an_idx == IW'(i));
        end
        mask_next = frame_mask | digit_sel;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (an_valid) begin
                    state_next = TRACK;
                end
            end
            TRACK: begin
                if (!an_valid) begin
                    state_next = IDLE;
                end else if (capture) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (!an_valid) begin
                    state_next = IDLE;
                end else if (changed) begin
                    state_next = TRACK;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: when to capture and when the stability counter restarts.
    always_comb begin
        capture = (state == TRACK) && an_valid && !changed && (cnt == CAPTURE_AT);
        cnt_clr = (state == IDLE) || changed;
    end

    // Saturating count of consecutive unchanged samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Capture datapath: digit registers, valid flags, frame tracking and pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd         <= '1;
            digit_valid <= '0;
            frame_mask  <= '0;
            err         <= 1'b0;
            frame_stb   <= 1'b0;
        end else begin
            err       <= 1'b0;
            frame_stb <= 1'b0;
            if (capture) begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (digit_sel[i]) begin
                        bcd[4*i +: 4]  <= nibble;
                        digit_valid[i] <= 1'b1;
                    end
                end
                err <= seg_bad;
                if (mask_next == '1) begin
                    frame_stb  <= 1'b1;
                    frame_mask <= '0;
                end else begin
                    frame_mask <= mask_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_to_bcd_capture.sv
// tb_seg7_to_bcd_capture
// Table-driven bench: each record holds a bus pattern, how long it is held and
// the outputs expected afterwards, including the edge at which OUT_BCD moves.
module tb_seg7_to_bcd_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] bcd;
    logic [3:0]  digit_valid;
    logic        err;
    logic        frame_stb;

    int checks = 0;
    int errors = 0;

    int change_edge;
    int err_edge;
    int stb_edge;
    int err_count;
    int stb_count;

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        int          hold;
        logic [15:0] exp_bcd;
        logic [3:0]  exp_valid;
        int          exp_errs;
        int          exp_stbs;
        int          exp_edge;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    seg7_to_bcd_capture #(
        .DIGITS        (4),
        .STABLE_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg         (seg),
        .an          (an),
        .bcd         (bcd),
        .digit_valid (digit_valid),
        .err         (err),
        .frame_stb   (frame_stb)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Compare one observed value with its expected value.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Drive a bus pattern at a falling edge and watch the following rising edges.
    task automatic applyStimulus(input logic [3:0] an_v, input logic [6:0] seg_v, input int cycles);
        logic [15:0] start_bcd;
        @(negedge clk);
        an          = an_v;
        seg         = seg_v;
        start_bcd   = bcd;
        change_edge = 0;
        err_edge    = 0;
        stb_edge    = 0;
        err_count   = 0;
        stb_count   = 0;
        for (int e = 1; e <= cycles; e++) begin
            @(posedge clk);
            #1;
            if (bcd !== start_bcd && change_edge == 0) change_edge = e;
            if (err === 1'b1) begin
                err_count++;
                if (err_edge == 0) err_edge = e;
            end
            if (frame_stb === 1'b1) begin
                stb_count++;
                if (stb_edge == 0) stb_edge = e;
            end
        end
    endtask

    initial begin
        vecs[0]  = '{4'b1110, 7'b0010010, 20, 16'hFFF2, 4'b0001, 0, 0, 10};
        vecs[1]  = '{4'b1110, 7'b1001111, 12, 16'hFFF1, 4'b0001, 0, 0, 10};
        vecs[2]  = '{4'b1101, 7'b0010010, 12, 16'hFF21, 4'b0011, 0, 0, 10};
        vecs[3]  = '{4'b1011, 7'b0000110, 12, 16'hF321, 4'b0111, 0, 0, 10};
        vecs[4]  = '{4'b0111, 7'b1001100, 12, 16'h4321, 4'b1111, 0, 1, 10};
        vecs[5]  = '{4'b1101, 7'b1110000, 12, 16'h43E1, 4'b1111, 1, 0, 10};
        vecs[6]  = '{4'b1101, 7'b1111111, 12, 16'h43F1, 4'b1111, 0, 0, 10};
        vecs[7]  = '{4'b1101, 7'b0000000,  5, 16'h43F1, 4'b1111, 0, 0, 0};
        vecs[8]  = '{4'b1101, 7'b1111111, 20, 16'h43F1, 4'b1111, 0, 0, 0};
        vecs[9]  = '{4'b1100, 7'b0000000, 20, 16'h43F1, 4'b1111, 0, 0, 0};
        vecs[10] = '{4'b1111, 7'b0000000, 20, 16'h43F1, 4'b1111, 0, 0, 0};
        vecs[11] = '{4'b1110, 7'b0100100, 12, 16'h43F5, 4'b1111, 0, 0, 10};
        vecs[12] = '{4'b1011, 7'b0000100, 12, 16'h49F5, 4'b1111, 0, 0, 10};
        vecs[13] = '{4'b0111, 7'b0110000, 12, 16'hE9F5, 4'b1111, 1, 1, 10};
        vecs[14] = '{4'b1101, 7'b0001101, 12, 16'hE975, 4'b1111, 0, 0, 10};
        vecs[15] = '{4'b1011, 7'b0100000, 12, 16'hE675, 4'b1111, 0, 0, 10};
        vecs[16] = '{4'b1110, 7'b0000001, 12, 16'hE670, 4'b1111, 0, 0, 10};
        vecs[17] = '{4'b1110, 7'b0000000, 12, 16'hE678, 4'b1111, 0, 0, 10};

        // Reset held for three edges with the bus idle.
        rst_n = 1'b0;
        an    = 4'b1111;
        seg   = 7'b1111111;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset bcd", 32'(bcd), 32'hFFFF);
        checkOutput("reset valid", 32'(digit_valid), 32'h0);
        checkOutput("reset err", 32'(err), 32'h0);
        checkOutput("reset stb", 32'(frame_stb), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].an, vecs[i].seg, vecs[i].hold);
            checkOutput($sformatf("v%0d bcd", i), 32'(bcd), 32'(vecs[i].exp_bcd));
            checkOutput($sformatf("v%0d valid", i), 32'(digit_valid), 32'(vecs[i].exp_valid));
            checkOutput($sformatf("v%0d err count", i), 32'(err_count), 32'(vecs[i].exp_errs));
            checkOutput($sformatf("v%0d stb count", i), 32'(stb_count), 32'(vecs[i].exp_stbs));
            checkOutput($sformatf("v%0d update edge", i), 32'(change_edge), 32'(vecs[i].exp_edge));
            if (vecs[i].exp_stbs != 0)
                checkOutput($sformatf("v%0d stb edge", i), 32'(stb_edge), 32'(vecs[i].exp_edge));
            if (vecs[i].exp_errs != 0)
                checkOutput($sformatf("v%0d err edge", i), 32'(err_edge), 32'(vecs[i].exp_edge));
        end

        // Reset lands while a digit-2 capture is one edge from completing.
        applyStimulus(4'b1011, 7'b1001111, 9);
        checkOutput("pre-reset no capture", 32'(change_edge), 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("mid reset bcd", 32'(bcd), 32'hFFFF);
        checkOutput("mid reset valid", 32'(digit_valid), 32'h0);
        checkOutput("mid reset err", 32'(err), 32'h0);
        rst_n = 1'b1;
        applyStimulus(4'b1011, 7'b1001111, 12);
        checkOutput("post reset bcd", 32'(bcd), 32'hF1FF);
        checkOutput("post reset valid", 32'(digit_valid), 32'h4);
        checkOutput("post reset update edge", 32'(change_edge), 32'd10);
        checkOutput("post reset err count", 32'(err_count), 32'h0);
        checkOutput("post reset stb count", 32'(stb_count), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
